// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder sequencer: time-shares one WIDTH-bit combinational
// adder slice over CHUNKS cycles to build a WIDTH*CHUNKS-bit add/subtract.
module add_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    input  logic                      c_in,
    input  logic                      sub,
    output logic [WIDTH-1:0]          slice_a,
    output logic [WIDTH-1:0]          slice_b,
    output logic [WIDTH-1:0]          slice_p,
    output logic                      slice_c_in,
    input  logic [WIDTH-1:0]          slice_s,
    input  logic                      slice_c_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   sum,
    output logic                      c_out
);

    localparam int N  = WIDTH * CHUNKS;
    localparam int KW = $clog2(CHUNKS);
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    sum_q;
    logic            carry_q;
    logic            c_out_q;
    logic [KW-1:0]   k_q;
    logic            accept;
    logic            step;
    logic            last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (k_q == K_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B is stored pre-inverted so subtract is A + ~B + 1 on the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            k_q     <= '0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub | c_in;
                k_q     <= '0;
            end
            if (step) begin
                sum_q[k_q*WIDTH +: WIDTH] <= slice_s;
                carry_q                   <= slice_c_out;
                if (last) begin
                    c_out_q <= slice_c_out;
                end else begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    // Slice inputs are held at zero outside RUN to keep it quiet
    always_comb begin
        slice_a    = '0;
        slice_b    = '0;
        slice_c_in = 1'b0;
        if (state_q == RUN) begin
            slice_a    = a_q[k_q*WIDTH +: WIDTH];
            slice_b    = b_q[k_q*WIDTH +: WIDTH];
            slice_c_in = carry_q;
        end
    end

    assign slice_p = slice_a ^ slice_b;
    assign sum     = sum_q;
    assign c_out   = c_out_q;

endmodule
